// File: rtl/alu_vec_pkg.sv
// Shared vector geometry, operation codes and the loader/writeback state encoding.
package alu_vec_pkg;

    localparam int LANES  = 16;
    localparam int LANE_W = 32;
    localparam int VEC_W  = LANES * LANE_W;
    localparam int IDX_W  = $clog2(LANES);

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // True when the lane counter points at the final lane of a vector.
    function automatic logic is_last_lane(input logic [IDX_W-1:0] idx);
        return idx == IDX_W'(LANES - 1);
    endfunction

endpackage

// File: rtl/alu_operand_loader_if.sv
// Word stream in, assembled operand vectors out.
// master = the upstream/consumer side, slave = the loader.
interface alu_operand_loader_if;
    import alu_vec_pkg::*;

    logic              word_valid;
    logic              word_ready;
    logic [LANE_W-1:0] word_data;
    logic [VEC_W-1:0]  in1;
    logic [VEC_W-1:0]  in2;
    logic              operation;
    logic              opnd_valid;
    logic              opnd_ack;

    modport master (
        output word_valid, word_data, opnd_ack,
        input  word_ready, in1, in2, operation, opnd_valid
    );

    modport slave (
        input  word_valid, word_data, opnd_ack,
        output word_ready, in1, in2, operation, opnd_valid
    );

endinterface

// File: rtl/vec_lane_bank.sv
// LANES x LANE_W register bank, one lane written per enabled cycle, flat vector view out.
module vec_lane_bank
    import alu_vec_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_lane,
    input  logic [LANE_W-1:0] i_data,
    output logic [VEC_W-1:0]  o_vec
);

    logic [LANES-1:0][LANE_W-1:0] r_lanes;

    // Write the addressed lane; untouched lanes keep their previous contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lanes <= '0;
        end else if (i_we) begin
            r_lanes[i_lane] <= i_data;
        end
    end

    // Lane i sits at bits [LANE_W*i +: LANE_W], exactly the packed layout.
    assign o_vec = r_lanes;

endmodule

// File: rtl/alu_operand_loader.sv
// Assembles two operand vectors from a 32-bit word stream and holds them for the SIMD ALU.
//
//  state  | meaning
//  -------+--------------------------------------------------------------
//  IDLE   | waiting for start; op latched on the accepting edge
//  LOAD_A | accepting words into in1, lane 0..15
//  LOAD_B | accepting words into in2, lane 0..15
//  HOLD   | vectors complete, opnd_valid high until the consumer acks
module alu_operand_loader
    import alu_vec_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic op_in,
    input  logic flush,
    output logic busy,
    alu_operand_loader_if.slave bus
);

    state_t           r_state;
    logic [IDX_W-1:0] r_lane_idx;
    logic             r_operation;

    logic w_word_ready;
    logic w_xfer;
    logic w_we_a;
    logic w_we_b;

    // Flush blocks acceptance combinationally so the flush-cycle word is never written.
    assign w_word_ready = ((r_state == LOAD_A) || (r_state == LOAD_B)) && !flush;
    assign w_xfer       = bus.word_valid && w_word_ready;
    assign w_we_a       = w_xfer && (r_state == LOAD_A);
    assign w_we_b       = w_xfer && (r_state == LOAD_B);

    // Sequencing FSM with lane counter and operation latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_lane_idx  <= '0;
            r_operation <= OP_ADD;
        end else if (flush) begin
            // Vectors and operation deliberately survive an abort.
            r_state    <= IDLE;
            r_lane_idx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= LOAD_A;
                        r_operation <= op_in;
                        r_lane_idx  <= '0;
                    end
                end
                LOAD_A: begin
                    if (w_xfer) begin
                        r_lane_idx <= r_lane_idx + IDX_W'(1);
                        if (is_last_lane(r_lane_idx)) begin
                            r_state <= LOAD_B;
                        end
                    end
                end
                LOAD_B: begin
                    if (w_xfer) begin
                        r_lane_idx <= r_lane_idx + IDX_W'(1);
                        if (is_last_lane(r_lane_idx)) begin
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.opnd_ack) begin
                        if (start) begin
                            r_state     <= LOAD_A;
                            r_operation <= op_in;
                            r_lane_idx  <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_lane_idx <= '0;
                end
            endcase
        end
    end

    vec_lane_bank u_bank_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_we_a),
        .i_lane (r_lane_idx),
        .i_data (bus.word_data),
        .o_vec  (bus.in1)
    );

    vec_lane_bank u_bank_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_we_b),
        .i_lane (r_lane_idx),
        .i_data (bus.word_data),
        .o_vec  (bus.in2)
    );

    assign bus.word_ready = w_word_ready;
    assign bus.operation  = r_operation;
    assign bus.opnd_valid = (r_state == HOLD);
    assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a scoreboard of expected operand sets.
module tb_alu_operand_loader;
    import alu_vec_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic op_in;
    logic flush;
    logic busy;

    alu_operand_loader_if u_if ();

    alu_operand_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op_in (op_in),
        .flush (flush),
        .busy  (busy),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [VEC_W-1:0] a;
        logic [VEC_W-1:0] b;
        logic             op;
    } res_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc;
    logic [31:0] exp_a [LANES];
    logic [31:0] exp_b [LANES];
    logic        exp_op;
    res_t        sb [$];
    res_t        last_res;

    task automatic chk(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VEC_W-1:0] pack_vec(input bit sel_b);
        logic [VEC_W-1:0] v;
        for (int i = 0; i < LANES; i++)
            v[32*i +: 32] = sel_b ? exp_b[i] : exp_a[i];
        return v;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < LANES; i++) begin
            exp_a[i] = '0;
            exp_b[i] = '0;
        end
        exp_op = 1'b0;
    endtask

    task automatic start_load(input logic op);
        start = 1'b1;
        op_in = op;
        step();
        start  = 1'b0;
        exp_op = op;
        cyc    = 1;
    endtask

    // Streams words first..first+n-1 (word k = base+k); a completed load is queued as expected.
    task automatic feed(input int first, input int n, input logic [31:0] base, input bit gaps);
        for (int k = first; k < first + n; k++) begin
            if (gaps) begin
                u_if.word_valid = 1'b0;
                u_if.word_data  = 32'h0BAD_0000;
                step();
                cyc++;
            end
            u_if.word_valid = 1'b1;
            u_if.word_data  = base + 32'(k);
            if (k == 31) chk("valid_before_last_word", u_if.opnd_valid, 1'b0);
            if (k < LANES) exp_a[k] = u_if.word_data;
            else           exp_b[k - LANES] = u_if.word_data;
            step();
            cyc++;
        end
        u_if.word_valid = 1'b0;
        if (first + n == 2 * LANES)
            sb.push_back(res_t'{a: pack_vec(1'b0), b: pack_vec(1'b1), op: exp_op});
    endtask

    task automatic check_hold(input string tag, input int exp_cyc);
        chk({tag, "_opnd_valid"}, u_if.opnd_valid, 1'b1);
        chk({tag, "_latency"}, cyc, exp_cyc);
        chk({tag, "_word_ready"}, u_if.word_ready, 1'b0);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            last_res = sb.pop_front();
            chk({tag, "_in1"}, u_if.in1, last_res.a);
            chk({tag, "_in2"}, u_if.in2, last_res.b);
            chk({tag, "_op"}, u_if.operation, last_res.op);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        start           = 1'b0;
        op_in           = 1'b0;
        flush           = 1'b0;
        u_if.word_valid = 1'b0;
        u_if.word_data  = '0;
        u_if.opnd_ack   = 1'b0;
        clear_model();
        #3;
        chk("rst_in1", u_if.in1, '0);
        chk("rst_in2", u_if.in2, '0);
        chk("rst_op", u_if.operation, 1'b0);
        chk("rst_word_ready", u_if.word_ready, 1'b0);
        chk("rst_opnd_valid", u_if.opnd_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Test 1: unstalled load, mul
        start_load(OP_MUL);
        chk("t1_busy", busy, 1'b1);
        feed(0, 32, 32'd1, 1'b0);
        check_hold("t1", 33);

        // Test 3: hold without ack, lone start pulse ignored
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            op_in = OP_ADD;
            step();
            chk("t3_opnd_valid", u_if.opnd_valid, 1'b1);
            chk("t3_word_ready", u_if.word_ready, 1'b0);
            chk("t3_in1", u_if.in1, last_res.a);
            chk("t3_in2", u_if.in2, last_res.b);
            chk("t3_op", u_if.operation, last_res.op);
        end
        start         = 1'b0;
        u_if.opnd_ack = 1'b1;
        step();
        u_if.opnd_ack = 1'b0;
        chk("t3_busy_after_ack", busy, 1'b0);
        chk("t3_valid_after_ack", u_if.opnd_valid, 1'b0);

        // Test 2: word_valid toggling every cycle
        start_load(OP_MUL);
        feed(0, 32, 32'd1, 1'b1);
        check_hold("t2", 65);

        // Test 4: back-to-back start with ack, add, sign bits preserved
        u_if.opnd_ack = 1'b1;
        start         = 1'b1;
        op_in         = OP_ADD;
        step();
        u_if.opnd_ack = 1'b0;
        start         = 1'b0;
        exp_op        = OP_ADD;
        cyc           = 1;
        chk("t4_busy", busy, 1'b1);
        chk("t4_opnd_valid", u_if.opnd_valid, 1'b0);
        chk("t4_op", u_if.operation, OP_ADD);
        chk("t4_word_ready", u_if.word_ready, 1'b1);
        feed(0, 1, 32'hFFFF_FFFF, 1'b0);
        chk("t4_in1_lane0", u_if.in1[31:0], 32'hFFFF_FFFF);
        chk("t4_in2_unchanged", u_if.in2, last_res.b);
        feed(1, 31, 32'h8000_0000, 1'b0);
        check_hold("t4", 33);
        u_if.opnd_ack = 1'b1;
        step();
        u_if.opnd_ack = 1'b0;

        // Test 5: flush after 20 words, then reload from lane 0
        start_load(OP_MUL);
        feed(0, 20, 32'h5000_0000, 1'b0);
        u_if.word_valid = 1'b1;
        u_if.word_data  = 32'hDEAD_BEEF;
        flush           = 1'b1;
        #1;
        chk("t5_ready_in_flush", u_if.word_ready, 1'b0);
        step();
        flush           = 1'b0;
        u_if.word_valid = 1'b0;
        chk("t5_busy", busy, 1'b0);
        chk("t5_in1_kept", u_if.in1, pack_vec(1'b0));
        chk("t5_in2_partial", u_if.in2, pack_vec(1'b1));
        chk("t5_op_kept", u_if.operation, OP_MUL);
        start_load(OP_ADD);
        feed(0, 1, 32'h7000_0000, 1'b0);
        chk("t5_reload_lane0", u_if.in1[31:0], 32'h7000_0000);
        feed(1, 31, 32'h7000_0000, 1'b0);
        check_hold("t5", 33);
        u_if.opnd_ack = 1'b1;
        step();
        u_if.opnd_ack = 1'b0;

        // Test 6: asynchronous reset in the middle of LOAD_B
        start_load(OP_MUL);
        feed(0, 20, 32'h9000_0000, 1'b0);
        u_if.word_valid = 1'b1;
        u_if.word_data  = 32'h1234_5678;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_in1", u_if.in1, '0);
        chk("t6_in2", u_if.in2, '0);
        chk("t6_op", u_if.operation, 1'b0);
        chk("t6_word_ready", u_if.word_ready, 1'b0);
        chk("t6_opnd_valid", u_if.opnd_valid, 1'b0);
        chk("t6_busy", busy, 1'b0);
        clear_model();
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("t6_idle_busy", busy, 1'b0);
        chk("t6_idle_ready", u_if.word_ready, 1'b0);
        chk("t6_idle_in1", u_if.in1, '0);
        u_if.word_valid = 1'b0;
        start_load(OP_MUL);
        feed(0, 32, 32'hC000_0000, 1'b0);
        check_hold("t6", 33);
        u_if.opnd_ack = 1'b1;
        step();
        u_if.opnd_ack = 1'b0;
        chk("t6_final_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
